mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arb_if.sv | 41 ++++
 rtl/mem_arb.sv | 111 +++++++++++
 tb/tb_mem_arb.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: read-return tags and owner state.
// Also used by the video fetcher, so keep encodings stable.
package mem_arb_pkg;

    localparam int DW = 18;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VID  = 2'd2
    } tag_e;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_e;

    // Writes produce no read return, so they tag as NONE.
    function automatic tag_e read_tag(input owner_e owner, input logic we);
        tag_e tag;
        tag = TAG_NONE;
        if (owner == OWN_VID) begin
            tag = TAG_VID;
        end else if (owner == OWN_CPU && !we) begin
            tag = TAG_CPU;
        end
        return tag;
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// CPU, video and memory-side bus of the memory arbiter.
// master = requesters/memory side, slave = the arbiter.
interface mem_arb_if #(
    parameter int AW = 16
);
    import mem_arb_pkg::*;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_wd;
    logic          cpu_gnt;
    logic [DW-1:0] cpu_rd;
    logic          cpu_rvalid;

    logic          vid_req;
    logic [AW-1:0] vid_a;
    logic          vid_gnt;
    logic [DW-1:0] vid_rd;
    logic          vid_rvalid;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    owner_e        dbg_owner;

    modport master (
        output cpu_req, cpu_we, cpu_a, cpu_wd, vid_req, vid_a, mem_rd,
        input  cpu_gnt, cpu_rd, cpu_rvalid, vid_gnt, vid_rd, vid_rvalid,
               mem_a, mem_wd, mem_we, dbg_owner
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_a, cpu_wd, vid_req, vid_a, mem_rd,
        output cpu_gnt, cpu_rd, cpu_rvalid, vid_gnt, vid_rd, vid_rvalid,
               mem_a, mem_wd, mem_we, dbg_owner
    );

endinterface

// File: rtl/mem_arb.sv
// Two-port (CPU read/write, video read-only) arbiter for a synchronous memory.
// Video has priority, bounded by a burst counter so the CPU cannot starve.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int VID_BURST = 8
) (
    input  logic     clk,
    input  logic     res,
    mem_arb_if.slave bus
);

    localparam int            BW        = $clog2(VID_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(VID_BURST);

    logic          cpu_gnt;
    logic          vid_gnt;

    logic [BW-1:0] burst_q,      burst_d;
    logic [AW-1:0] mem_a_q,      mem_a_d;
    logic [DW-1:0] mem_wd_q,     mem_wd_d;
    logic          mem_we_q,     mem_we_d;
    owner_e        owner_q,      owner_d;
    tag_e          tag1_q,       tag1_d;
    tag_e          tag2_q,       tag2_d;
    logic          cpu_rvalid_q, cpu_rvalid_d;
    logic          vid_rvalid_q, vid_rvalid_d;
    logic [DW-1:0] cpu_rd_q,     cpu_rd_d;
    logic [DW-1:0] vid_rd_q,     vid_rd_d;

    // Grants are combinational; gating with res keeps both low during reset.
    always_comb begin
        vid_gnt = res && bus.vid_req && !(bus.cpu_req && (burst_q == BURST_MAX));
        cpu_gnt = res && bus.cpu_req && !vid_gnt;
    end

    always_comb begin
        burst_d  = burst_q;
        mem_a_d  = mem_a_q;
        mem_wd_d = mem_wd_q;
        mem_we_d = 1'b0;
        owner_d  = OWN_IDLE;

        if (cpu_gnt) begin
            mem_a_d  = bus.cpu_a;
            mem_wd_d = bus.cpu_wd;
            mem_we_d = bus.cpu_we;
            owner_d  = OWN_CPU;
        end else if (vid_gnt) begin
            mem_a_d  = bus.vid_a;
            owner_d  = OWN_VID;
        end

        // Counts video wins only while the CPU is actually waiting.
        if (!bus.cpu_req || cpu_gnt) begin
            burst_d = '0;
        end else if (vid_gnt && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + 1'b1;
        end

        tag1_d = read_tag(owner_d, bus.cpu_we);
        tag2_d = tag1_q;

        // mem_rd now holds the data for the access tagged two edges ago.
        cpu_rvalid_d = (tag2_q == TAG_CPU);
        vid_rvalid_d = (tag2_q == TAG_VID);
        cpu_rd_d     = cpu_rvalid_d ? bus.mem_rd : cpu_rd_q;
        vid_rd_d     = vid_rvalid_d ? bus.mem_rd : vid_rd_q;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            burst_q      <= '0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_we_q     <= 1'b0;
            owner_q      <= OWN_IDLE;
            tag1_q       <= TAG_NONE;
            tag2_q       <= TAG_NONE;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rd_q     <= '0;
            vid_rd_q     <= '0;
        end else begin
            burst_q      <= burst_d;
            mem_a_q      <= mem_a_d;
            mem_wd_q     <= mem_wd_d;
            mem_we_q     <= mem_we_d;
            owner_q      <= owner_d;
            tag1_q       <= tag1_d;
            tag2_q       <= tag2_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rd_q     <= cpu_rd_d;
            vid_rd_q     <= vid_rd_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.vid_gnt    = vid_gnt;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_wd     = mem_wd_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vid_rvalid = vid_rvalid_q;
    assign bus.cpu_rd     = cpu_rd_q;
    assign bus.vid_rd     = vid_rd_q;
    assign bus.dbg_owner  = owner_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural sync RAM, a grant/burst model
// and per-port read-return scoreboards.
module tb_mem_arb;
    import mem_arb_pkg::*;

    localparam int AW = 16;
    localparam int VB = 8;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if #(.AW(AW)) bus ();

    mem_arb #(.AW(AW), .VID_BURST(VB)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cpu_rv_cnt = 0;
    int vid_rv_cnt = 0;

    // Behavioural synchronous RAM on the memory side.
    logic [DW-1:0] store [256];
    bit            written [256];

    // Bench's own view of memory contents and arbitration.
    logic [DW-1:0] sh_store [256];
    bit            sh_written [256];
    int            burst_m = 0;
    logic          exp_cgnt = 1'b0;
    logic          exp_vgnt = 1'b0;
    logic          exp_we = 1'b0;
    logic [AW-1:0] exp_a = '0;
    logic [DW-1:0] exp_wd = '0;
    logic [DW-1:0] exp_cpu_rd = '0;
    logic [DW-1:0] exp_vid_rd = '0;
    rd_t           cpu_q [$];
    rd_t           vid_q [$];

    function automatic logic [DW-1:0] pat(input logic [7:0] a);
        return {2'b10, a ^ 8'hC3, a};
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [7:0] a);
        return sh_written[a] ? sh_store[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (bus.mem_we) begin
            store[bus.mem_a[7:0]]   <= bus.mem_wd;
            written[bus.mem_a[7:0]] <= 1'b1;
        end
        bus.mem_rd <= written[bus.mem_a[7:0]] ? store[bus.mem_a[7:0]] : pat(bus.mem_a[7:0]);
    end

    // Model update at each edge, using grants predicted at the previous negedge.
    always @(posedge clk) begin
        cyc++;
        if (res) begin
            if (exp_cgnt) begin
                exp_a  = bus.cpu_a;
                exp_wd = bus.cpu_wd;
                exp_we = bus.cpu_we;
                if (bus.cpu_we) begin
                    sh_store[bus.cpu_a[7:0]]   = bus.cpu_wd;
                    sh_written[bus.cpu_a[7:0]] = 1'b1;
                end else begin
                    cpu_q.push_back('{data: model_rd(bus.cpu_a[7:0]), due: cyc + 2});
                end
            end else if (exp_vgnt) begin
                exp_a  = bus.vid_a;
                exp_we = 1'b0;
                vid_q.push_back('{data: model_rd(bus.vid_a[7:0]), due: cyc + 2});
            end else begin
                exp_we = 1'b0;
            end
            if (!bus.cpu_req || exp_cgnt) burst_m = 0;
            else if (exp_vgnt && burst_m < VB) burst_m++;
        end
    end

    // Per-cycle comparison of grants, memory strobes and read returns.
    always @(negedge clk) begin
        logic exp_crv;
        logic exp_vrv;
        rd_t  e;
        if (!res) begin
            cpu_q.delete();
            vid_q.delete();
            burst_m    = 0;
            exp_we     = 1'b0;
            exp_a      = '0;
            exp_wd     = '0;
            exp_cpu_rd = '0;
            exp_vid_rd = '0;
        end
        exp_vgnt = res && bus.vid_req && !(bus.cpu_req && burst_m == VB);
        exp_cgnt = res && bus.cpu_req && !exp_vgnt;
        chk("vid_gnt", bus.vid_gnt, exp_vgnt);
        chk("cpu_gnt", bus.cpu_gnt, exp_cgnt);
        chk("mem_we", bus.mem_we, exp_we);
        chk("mem_a", bus.mem_a, exp_a);
        chk("mem_wd", bus.mem_wd, exp_wd);

        exp_crv = (cpu_q.size() != 0) && (cpu_q[0].due == cyc);
        chk("cpu_rvalid", bus.cpu_rvalid, exp_crv);
        if (exp_crv) begin
            e = cpu_q.pop_front();
            exp_cpu_rd = e.data;
        end
        chk("cpu_rd", bus.cpu_rd, exp_cpu_rd);
        while (cpu_q.size() != 0 && cpu_q[0].due < cyc) void'(cpu_q.pop_front());

        exp_vrv = (vid_q.size() != 0) && (vid_q[0].due == cyc);
        chk("vid_rvalid", bus.vid_rvalid, exp_vrv);
        if (exp_vrv) begin
            e = vid_q.pop_front();
            exp_vid_rd = e.data;
        end
        chk("vid_rd", bus.vid_rd, exp_vid_rd);
        while (vid_q.size() != 0 && vid_q[0].due < cyc) void'(vid_q.pop_front());

        if (bus.cpu_rvalid) cpu_rv_cnt++;
        if (bus.vid_rvalid) vid_rv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_we"}, bus.mem_we, 0);
        chk({tag, "_mem_a"}, bus.mem_a, 0);
        chk({tag, "_mem_wd"}, bus.mem_wd, 0);
        chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        chk({tag, "_vid_rvalid"}, bus.vid_rvalid, 0);
        chk({tag, "_cpu_rd"}, bus.cpu_rd, 0);
        chk({tag, "_vid_rd"}, bus.vid_rd, 0);
        chk({tag, "_cpu_gnt"}, bus.cpu_gnt, 0);
        chk({tag, "_vid_gnt"}, bus.vid_gnt, 0);
        chk({tag, "_owner"}, bus.dbg_owner, OWN_IDLE);
    endtask

    initial begin
        int cbase;
        int vbase;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_a = '0; bus.cpu_wd = '0;
        bus.vid_req = 1'b0; bus.vid_a = '0;

        // Reset with both requests high: grants must stay low.
        #1;
        res = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h1234; bus.cpu_wd = 18'h3FFFF;
        bus.vid_req = 1'b1; bus.vid_a = 16'h0077;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        res = 1'b1;
        tick(2);

        // CPU write then read of the same address.
        cbase = cpu_rv_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h0010; bus.cpu_wd = 18'h2A5A5;
        tick(1);
        bus.cpu_we = 1'b0; bus.cpu_wd = 18'h00000;
        @(negedge clk);
        chk("owner_after_cpu", bus.dbg_owner, OWN_CPU);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        tick(4);
        chk("cpu_rw_returns", cpu_rv_cnt - cbase, 1);
        chk("cpu_rw_data", bus.cpu_rd, 18'h2A5A5);
        @(negedge clk);
        chk("owner_idle", bus.dbg_owner, OWN_IDLE);
        tick(1);

        // Contention: 8 video grants then 1 CPU grant, repeating.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0020;
        bus.vid_req = 1'b1; bus.vid_a = 16'h0030;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("contention_cpu_gnt", bus.cpu_gnt, (i % 9) == 8);
            @(posedge clk); #1;
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        tick(4);

        // Back-to-back video reads at addresses 0..3.
        vbase = vid_rv_cnt;
        for (int a = 0; a < 4; a++) begin
            bus.vid_req = 1'b1; bus.vid_a = AW'(a);
            tick(1);
        end
        bus.vid_req = 1'b0;
        tick(4);
        chk("b2b_vid_returns", vid_rv_cnt - vbase, 4);
        chk("b2b_last_data", bus.vid_rd, pat(8'd3));

        // CPU read then video read on consecutive edges.
        cbase = cpu_rv_cnt; vbase = vid_rv_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0010;
        tick(1);
        bus.cpu_req = 1'b0;
        bus.vid_req = 1'b1; bus.vid_a = 16'h0005;
        tick(1);
        bus.vid_req = 1'b0;
        tick(4);
        chk("ilv_cpu_returns", cpu_rv_cnt - cbase, 1);
        chk("ilv_vid_returns", vid_rv_cnt - vbase, 1);
        chk("ilv_cpu_data", bus.cpu_rd, 18'h2A5A5);
        chk("ilv_vid_data", bus.vid_rd, pat(8'h05));

        // Reset one cycle after a CPU read accept discards the read.
        cbase = cpu_rv_cnt;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0010;
        tick(1);
        bus.cpu_req = 1'b0;
        tick(1);
        res = 1'b0;
        bus.cpu_req = 1'b1; bus.vid_req = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        res = 1'b1;
        tick(5);
        chk("no_rvalid_after_reset", cpu_rv_cnt - cbase, 0);

        // CPU write request dropped while video holds priority.
        bus.vid_req = 1'b1; bus.vid_a = 16'h0031;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h0040; bus.cpu_wd = 18'h15555;
        tick(1);
        bus.cpu_req = 1'b0;
        tick(2);
        // A cleared burst counter lets video win exactly 8 times before the CPU.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0040;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("dropped_burst_cpu_gnt", bus.cpu_gnt, i == 8);
            @(posedge clk); #1;
        end
        bus.cpu_req = 1'b0; bus.vid_req = 1'b0;
        tick(4);
        chk("dropped_no_write", bus.cpu_rd, pat(8'h40));

        chk("cpu_q_drained", cpu_q.size(), 0);
        chk("vid_q_drained", vid_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
